// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data accesses onto one memory port, data first, with a one-word fetch buffer
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          istall,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dstall,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic [DW-1:0] mrdata,
  input  logic          mready
);
  typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;
  state_t        r_state, w_next;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wdata;
  logic          r_ibuf_valid;
  logic [AW-3:0] r_ibuf_tag;
  logic [DW-1:0] r_ibuf_data;
  logic          r_ddone;
  logic [DW-1:0] r_dbuf_data;
  logic          w_ihit, w_dgo, w_igo, w_dfin, w_ifin;
  assign w_ihit = r_ibuf_valid && r_ibuf_tag == iaddr[AW-1:2];
  assign istall = ireq && !w_ihit;
  assign dstall = dreq && !r_ddone;
  assign w_dgo  = r_state == IDLE && dstall;
  assign w_igo  = r_state == IDLE && !dstall && istall;
  assign w_dfin = r_state == DACC && mready;
  assign w_ifin = r_state == IACC && mready;
  assign irdata = r_ibuf_data;
  assign drdata = r_dbuf_data;
  assign mreq   = r_state != IDLE;
  assign mwe    = r_state == DACC && r_we;
  assign maddr  = r_addr;
  assign mwdata = r_wdata;
  // state register; reset abandons any in-flight access
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  // next state: data wins over fetch in IDLE, accesses wait for mready
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       w_next = w_dgo ? DACC : w_igo ? IACC : IDLE;
      DACC, IACC: w_next = mready ? IDLE : r_state;
      default:    w_next = IDLE;
    endcase
  end
  // request registers hold address/data stable for the whole access
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (w_dgo) begin
      r_addr  <= daddr;
      r_we    <= dwe;
      r_wdata <= dwdata;
    end else if (w_igo) begin
      r_addr  <= iaddr;
      r_we    <= 1'b0;
    end
  // result buffers: one-cycle data token, fetch buffer fill and store invalidate
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_ddone      <= 1'b0;
      r_dbuf_data  <= '0;
      r_ibuf_valid <= 1'b0;
      r_ibuf_tag   <= '0;
      r_ibuf_data  <= '0;
    end else begin
      r_ddone <= w_dfin;
      if (w_dfin && !r_we) r_dbuf_data <= mrdata;
      if (w_ifin) begin
        r_ibuf_valid <= 1'b1;
        r_ibuf_tag   <= r_addr[AW-1:2];
        r_ibuf_data  <= mrdata;
      end else if (w_dfin && r_we && r_addr[AW-1:2] == r_ibuf_tag) r_ibuf_valid <= 1'b0;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline fetch port (PC/instruction) and the memory-stage data port (load/store).
- Sits between the pipeline datapath and the memory.
- Serialises accesses with data having priority over fetch, and drives per-port stall signals into the hazard unit.
- Keeps a one-entry fetch buffer so a stalled or repeated fetch of the same word completes without re-accessing memory.

Parameters:
- AW, 32, address width in bits; word-aligned, bits [1:0] ignored.
- DW, 32, data width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; reset=0 resets the block.
- ireq  in  1  fetch request, held high each cycle the fetch stage needs a word.
- iaddr  in  AW  fetch address (pcf).
- irdata  out  DW  fetched instruction; valid when ireq=1 and istall=0.
- istall  out  1  fetch port must hold.
- dreq  in  1  data access request from memory stage.
- dwe  in  1  1=store, 0=load; qualifies dreq.
- daddr  in  AW  data address (aluoutm).
- dwdata  in  DW  store data (writedatam).
- drdata  out  DW  load result; valid when dreq=1 and dstall=0.
- dstall  out  1  data port must hold.
- mreq  out  1  memory request.
- mwe  out  1  memory write enable.
- maddr  out  AW  memory address.
- mwdata  out  DW  memory write data.
- mrdata  in  DW  memory read data, valid in the cycle mready=1.
- mready  in  1  memory completion, one-cycle pulse; ignored when mreq=0.

Behaviour:
- States: IDLE, DACC, IACC; 2-bit encoding.
- Reset values:
  - state=IDLE; mreq=0, mwe=0, maddr=0, mwdata=0.
  - ibuf_valid=0, ibuf_tag=0, ibuf_data=0.
  - ddone=0, dbuf_data=0; irdata=0, drdata=0.
- ihit = ibuf_valid && ibuf_tag==iaddr[AW-1:2].
- Stall outputs, combinational:
  - istall = ireq && !ihit.
  - dstall = dreq && !ddone.
- irdata = ibuf_data; drdata = dbuf_data.
- IDLE transitions:
  - If dreq && !ddone: latch daddr/dwe/dwdata into the request registers, go to DACC.
  - Else if ireq && !ihit: latch iaddr, go to IACC.
  - Else stay in IDLE.
  - Data always beats fetch when both are pending in the same cycle.
- DACC / IACC:
  - mreq=1; mwe = latched dwe in DACC, 0 in IACC.
  - maddr and mwdata come from the latched registers and are stable until mready.
  - Stay in the state while mready=0.
- On mready in DACC:
  - ddone<=1.
  - On a load: dbuf_data<=mrdata.
  - On a store whose word tag equals ibuf_tag: ibuf_valid<=0 (self-modifying-code invalidate).
  - Go to IDLE.
- On mready in IACC: ibuf_tag<=latched addr[AW-1:2], ibuf_data<=mrdata, ibuf_valid<=1; go to IDLE.
- ddone is a one-cycle token: if ddone=1, clear it at the next edge. The pipeline advances on the dstall=0 cycle, so no new access starts while ddone=1.
- Latency with zero-wait memory (mready in the first mreq cycle):
  - Cycle 0: request seen in IDLE.
  - Cycle 1: mreq=1, mready=1.
  - Cycle 2: stall low, data valid.
  - Each extra wait cycle adds one stall cycle.
- Fetch-miss cost: a data request arriving while IACC is in flight waits for it to finish. The worst-case data stall is the fetch latency plus its own latency.
- ireq/dreq dropping mid-transaction: the in-flight access still completes, with results buffered. A dropped data result is discarded via the ddone clear.
- mready while mreq=0: ignored, no state change.
- Asynchronous reset mid-transaction: immediate return to the reset values above and mreq drops. Memory must tolerate an abandoned request.
- Width rules: tag compares use [AW-1:2] only; no byte enables; whole-word writes.

Test Plan:
- Reset, then fetch iaddr=0x00000000 with memory word 0x20080005 and zero-wait memory. Required: istall high for cycles 0-1; cycle 2 istall=0, irdata=0x20080005; mreq asserted exactly one cycle.
- Same-cycle ireq (iaddr=0x4, fetch-buffer miss) and store (daddr=0x40, dwdata=0xDEADBEEF). Required: DACC first with mwe=1, maddr=0x40; dstall clears in cycle 2; IACC follows; istall clears in cycle 4.
- Load daddr=0x80 (word 0x12345678) with mready delayed 3 cycles. Required: maddr/mwe stable all wait cycles; dstall=0 in exactly one cycle with drdata=0x12345678, then ddone cleared.
- Fetch 0x10 to fill the buffer, then store to 0x10 with 0xCAFEF00D, then fetch 0x10 again. Required: second fetch misses (istall=1), re-accesses memory, returns 0xCAFEF00D.
- Fetch 0x8 held 5 cycles after it completes. Required: no further mreq, istall=0 throughout.
- Assert reset=0 during DACC with mready pending. Required: mreq=0 immediately; after release state=IDLE, istall/dstall follow requests, ibuf invalid.
